matrix_read_sched: RTL and testbench

Read-side scheduler for the three operand memories filled by the matrix loader. After the loader raises `done`, it streams the (even, odd) word pairs of memory a and memory b in lockstep, from address 0 up to `LAST_ADDR + 1`, using both BRAM ports per memory. It absorbs BRAM read latency in a small credit-controlled FIFO and presents each pair on a valid/ready interface to the downstream compute engine. It pulses `done` when the last pair has been accepted.

---
 rtl/matrix_read_sched_if.sv | 22 ++
 rtl/matrix_read_sched.sv | 148 ++++++++++++++
 tb/tb_matrix_read_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_read_sched_if.sv
// matrix_read_sched_if: operand pair stream from the read scheduler to the compute engine.
// master: out_valid, out_a0/a1/b0/b1 (driven); out_ready (sampled). slave: the reverse.
interface matrix_read_sched_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a0;
  logic [DATA_W-1:0] out_a1;
  logic [DATA_W-1:0] out_b0;
  logic [DATA_W-1:0] out_b1;

  modport master (
    output out_valid, out_a0, out_a1, out_b0, out_b1,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_a0, out_a1, out_b0, out_b1,
    output out_ready
  );
endinterface

// File: rtl/matrix_read_sched.sv
// matrix_read_sched: streams (even, odd) word pairs of memories a and b after start,
// buffering BRAM read latency in a credit-controlled FIFO.
// Ports: clk, reset (sync, active high), start; en*/addr* BRAM ports; dout* read data;
// stream (pair handshake, master); busy, done pulse, stall_cnt.
// Optional: define MATRIX_SCHED_STALL_CNT_EN to build the backpressure stall counter.
module matrix_read_sched #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int LAST_ADDR  = 8734,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ena,
  output logic              enA,
  output logic              enb,
  output logic              enB,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrA,
  output logic [ADDR_W-1:0] addrb,
  output logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] douta,
  input  logic [DATA_W-1:0] doutA,
  input  logic [DATA_W-1:0] doutb,
  input  logic [DATA_W-1:0] doutB,
  matrix_read_sched_if.master stream,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-2:0] K_LAST = (ADDR_W-1)'(LAST_ADDR / 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [ADDR_W-2:0]   k;
  logic [RD_LAT:0]     sr;
  logic [4*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         inflight, occ, limit;
  logic                issue, push, pop, en;
  logic [ADDR_W-1:0]   addr_e, addr_o;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++)
      inflight = inflight + {{CW{1'b0}}, sr[i]};
  end

  // sr tap high means dout* hold valid data this cycle
  assign push  = sr[RD_LAT];
  assign pop   = stream.out_valid & stream.out_ready;
  assign occ   = inflight + {1'b0, count};
  // a pop this cycle frees a slot that may be reclaimed at once
  assign limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        issue = occ < limit;
        if (issue && k == K_LAST) state_n = DRAIN;
      end
      DRAIN:
        if (inflight == '0 && count == '0 && !pop) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      sr     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      en     <= 1'b0;
      addr_e <= '0;
      addr_o <= '0;
    end else begin
      state <= state_n;
      sr    <= {sr[RD_LAT-1:0], issue};
      en    <= issue;
      if (state == IDLE && start)
        k <= '0;
      else if (issue)
        k <= k + 1'b1;
      if (issue) begin
        addr_e <= {k, 1'b0};
        addr_o <= {k, 1'b1};
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {douta, doutA, doutb, doutB};
  end

  assign ena   = en;
  assign enA   = en;
  assign enb   = en;
  assign enB   = en;
  assign addra = addr_e;
  assign addrb = addr_e;
  assign addrA = addr_o;
  assign addrB = addr_o;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  assign stream.out_valid = (count != '0);
  // stale FIFO contents stay hidden while empty
  assign {stream.out_a0, stream.out_a1, stream.out_b0, stream.out_b1} =
    stream.out_valid ? mem[rd_ptr] : '0;

`ifdef MATRIX_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (busy && stream.out_valid && !stream.out_ready
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_matrix_read_sched.sv
// tb_matrix_read_sched: three scheduler configurations against a pair-index model.
// Covers full pass, backpressure, RD_LAT=2, reset mid-pass, start while busy, minimum size.
module tb_matrix_read_sched;

  logic clk;
  int   errors = 0;
  int   checks = 0;
  int   fin = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int LA = (g == 0) ? 8734 : (g == 1) ? 14 : 0;
    localparam int RL = (g == 1) ? 2 : 1;
    localparam int NP = LA / 2 + 1;
    localparam int RK = (NP > 5) ? 5 : NP;

    logic        rst, start, ena, enA, enb, enB, busy, done;
    logic [13:0] addra, addrA, addrb, addrB;
    logic [31:0] douta, doutA, doutb, doutB;
    logic [15:0] stall_cnt;
    logic [55:0] pq [RL];
    logic        pv [RL];
    int cyc, nk, issued, pops, dones, stalls;
    int first_pop, last_pop, done_cyc, mode, n;

    matrix_read_sched_if #(.DATA_W(32)) s ();

    matrix_read_sched #(
      .ADDR_W(14), .DATA_W(32), .LAST_ADDR(LA),
      .RD_LAT(RL), .FIFO_DEPTH(4)
    ) dut (
      .clk(clk), .reset(rst), .start(start),
      .ena(ena), .enA(enA), .enb(enb), .enB(enB),
      .addra(addra), .addrA(addrA), .addrb(addrb), .addrB(addrB),
      .douta(douta), .doutA(doutA), .doutb(doutb), .doutB(doutB),
      .stream(s), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    function automatic string tag(input string t);
      return $sformatf("c%0d.%s", g, t);
    endfunction

    // BRAM: a[i] = i, b[i] = 0x1000_0000 + i, RL-cycle read latency
    always @(posedge clk) begin
      for (int i = RL - 1; i > 0; i--) begin
        pq[i] <= pq[i-1];
        pv[i] <= pv[i-1];
      end
      pq[0] <= {addra, addrA, addrb, addrB};
      pv[0] <= ena & enA & enb & enB;
    end

    assign douta = pv[RL-1] ? 32'(pq[RL-1][55:42]) : 32'hDEADBEEF;
    assign doutA = pv[RL-1] ? 32'(pq[RL-1][41:28]) : 32'hDEADBEEF;
    assign doutb = pv[RL-1] ? 32'h1000_0000 + 32'(pq[RL-1][27:14]) : 32'hDEADBEEF;
    assign doutB = pv[RL-1] ? 32'h1000_0000 + 32'(pq[RL-1][13:0]) : 32'hDEADBEEF;

    initial begin
      s.out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        if (mode == 1)
          s.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        else if (mode == 2)
          s.out_ready = ($urandom_range(3) != 0);
        else
          s.out_ready = 1'b1;
      end
    end

    // monitor: expected pair k is (2k, 2k+1, 0x1000_0000+2k, 0x1000_0000+2k+1)
    initial begin
      cyc = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (rst || (start && !busy && !done)) begin
          nk = 0; issued = 0; pops = 0; dones = 0; stalls = 0;
        end else begin
          if (ena | enA | enb | enB) begin
            chk(tag("rd"), {ena, enA, enb, enB, addra, addrA, addrb, addrB},
                {4'hF, 14'(2 * issued), 14'(2 * issued + 1),
                 14'(2 * issued), 14'(2 * issued + 1)});
            issued++;
            chk(tag("occ"), 128'((issued - pops) <= 4), 128'(1));
          end
          if (s.out_valid && s.out_ready) begin
            chk(tag("data"), {s.out_a0, s.out_a1, s.out_b0, s.out_b1},
                {32'(2 * nk), 32'(2 * nk + 1),
                 32'h1000_0000 + 32'(2 * nk), 32'h1000_0000 + 32'(2 * nk + 1)});
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            nk++;
            pops++;
          end
          if (busy && s.out_valid && !s.out_ready) stalls++;
          if (done) begin
            dones++;
            done_cyc = cyc;
          end
        end
      end
    end

    initial begin
      mode = 0; rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(tag("rst_ctl"), {ena, enA, enb, enB, busy, done, s.out_valid,
          addra, addrA, addrb, addrB, stall_cnt}, '0);
      chk(tag("rst_dat"), {s.out_a0, s.out_a1, s.out_b0, s.out_b1}, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
        mode = (p == 2) ? 1 : (p == 3) ? 2 : 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk(tag("busy"), 128'(busy), 128'(1));
        n = 0;
        if (p == 1) begin
          while (issued < RK && n < 100) begin
            @(negedge clk);
            n++;
          end
          @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
          @(negedge clk);
          chk(tag("mid_rst_ctl"), {ena, enA, enb, enB, busy, done, s.out_valid,
              addra, addrA, addrb, addrB, stall_cnt}, '0);
          chk(tag("mid_rst_dat"), {s.out_a0, s.out_a1, s.out_b0, s.out_b1}, '0);
          for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(tag("stale"), {s.out_valid, ena, busy}, '0);
          end
        end else begin
          while (!s.out_valid && n < 40) begin
            @(negedge clk);
            n++;
          end
          if (p == 0) chk(tag("lat"), 128'(n), 128'(2 + RL));
          n = 0;
          while (!done && n < 40000) begin
            @(posedge clk);
            #1 start = (p >= 2) && busy && ($urandom_range(3) == 0);
            @(negedge clk);
            n++;
          end
          start = 1'b0;
          chk(tag("done"), 128'(done), 128'(1));
          chk(tag("pairs"), 128'(nk), 128'(NP));
`ifdef MATRIX_SCHED_STALL_CNT_EN
          chk(tag("stall"), 128'(stall_cnt), 128'(stalls));
`else
          chk(tag("stall"), 128'(stall_cnt), 128'(0));
`endif
          @(negedge clk);
          chk(tag("pulse"), {done, 32'(dones)}, {1'b0, 32'd1});
          if (p == 0) begin
            chk(tag("tput"), 128'(last_pop - first_pop), 128'(LA / 2));
            chk(tag("done_lat"), 128'(done_cyc - last_pop), 128'(2));
          end
        end
      end
      fin++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (fin < 3 && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("finish", 128'(fin), 128'(3));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
